// File: rtl/swap_ci_controller.sv
// swap_ci_controller
//   Multi-cycle, extended-opcode custom instruction that routes one byte per
//   enabled cycle through a shared 8-bit lane to byte-swap 32-bit operands. It
//   also keeps a running sum of byte-reversed words.
//
//   Opcodes (n): 0 BSWAP32, 1 BSWAP16, 2 ACCUM (acc += bswap32), 3 READCLR.
//
// Ports
//   clk     in   custom-instruction clock, rising edge
//   reset_n in   asynchronous active-low reset
//   clk_en  in   high = advance, low = every register holds
//   start   in   one-cycle issue pulse, honoured only in IDLE
//   n       in   [1:0]  extended opcode, captured with start
//   dataa   in   [31:0] operand, captured with start
//   result  out  [31:0] registered result, held until the next completion
//   done    out  registered, high for one enabled cycle per instruction
//   busy    out  high whenever the controller is not IDLE
module swap_ci_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic [1:0]  n,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StLane,
        StDone
    } state_t;

    localparam logic [1:0] OpBswap32 = 2'd0;
    localparam logic [1:0] OpBswap16 = 2'd1;
    localparam logic [1:0] OpAccum   = 2'd2;
    localparam logic [1:0] OpReadClr = 2'd3;

    state_t      state;
    logic [1:0]  op_q;
    logic [31:0] src_q;
    logic [31:0] work_q;
    logic [1:0]  lane_cnt;
    logic [31:0] acc_q;

    logic [7:0]  lane_byte;
    logic [1:0]  dst_idx;
    logic [31:0] work_next;
    logic [31:0] acc_sum;

    assign busy = (state != StIdle);

    // The shared lane: pick source byte lane_cnt, steer it to its destination.
    always_comb begin
        lane_byte = 8'h00;
        unique case (lane_cnt)
            2'd0: lane_byte = src_q[7:0];
            2'd1: lane_byte = src_q[15:8];
            2'd2: lane_byte = src_q[23:16];
            2'd3: lane_byte = src_q[31:24];
            default: lane_byte = 8'h00;
        endcase

        dst_idx = (op_q == OpBswap16) ? (lane_cnt ^ 2'd1) : (2'd3 - lane_cnt);

        work_next = work_q;
        unique case (dst_idx)
            2'd0: work_next[7:0]   = lane_byte;
            2'd1: work_next[15:8]  = lane_byte;
            2'd2: work_next[23:16] = lane_byte;
            2'd3: work_next[31:24] = lane_byte;
            default: work_next = work_q;
        endcase

        // Includes the final byte so the DONE load sees the complete word.
        acc_sum = acc_q + work_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= StIdle;
            op_q     <= 2'd0;
            src_q    <= 32'h0;
            work_q   <= 32'h0;
            lane_cnt <= 2'd0;
            acc_q    <= 32'h0;
            result   <= 32'h0;
            done     <= 1'b0;
        end else if (clk_en) begin
            unique case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q  <= n;
                        src_q <= dataa;
                        if (n == OpReadClr) begin
                            result <= acc_q;
                            acc_q  <= 32'h0;
                            done   <= 1'b1;
                            state  <= StDone;
                        end else begin
                            lane_cnt <= 2'd0;
                            state    <= StLane;
                        end
                    end
                end
                StLane: begin
                    work_q   <= work_next;
                    lane_cnt <= lane_cnt + 2'd1;
                    if (lane_cnt == 2'd3) begin
                        done  <= 1'b1;
                        state <= StDone;
                        if (op_q == OpAccum) begin
                            acc_q  <= acc_sum;
                            result <= acc_sum;
                        end else begin
                            result <= work_next;
                        end
                    end
                end
                StDone: begin
                    // A start seen here is dropped; issue only from IDLE.
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

    logic unused_op;
    assign unused_op = (OpBswap32 == 2'd0);

endmodule

// File: tb/tb_swap_ci_controller.sv
// tb_swap_ci_controller
//   Directed-vector bench for swap_ci_controller. Outputs are sampled on the
//   falling clock edge; cycle numbers count from the cycle in which start is high.
`timescale 1ns/1ps
module tb_swap_ci_controller;

    logic        clk;
    logic        reset_n;
    logic        clk_en;
    logic        start;
    logic [1:0]  n;
    logic [31:0] dataa;
    logic [31:0] result;
    logic        done;
    logic        busy;

    int n_checks;
    int n_fail;

    swap_ci_controller dut (
        .clk    (clk),
        .reset_n(reset_n),
        .clk_en (clk_en),
        .start  (start),
        .n      (n),
        .dataa  (dataa),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one instruction and watch cycles 1..exp_cyc+3.
    // inject: cycle in which a stray start is driven (0 = none).
    // stall_lo..stall_hi: cycles with clk_en low (lo=0 = none).
    task automatic run_op(input logic [1:0] op, input logic [31:0] d, input int exp_cyc,
                          input logic [31:0] exp_res, input int inject, input int stall_lo,
                          input int stall_hi, input string tag, input bit trace);
        int          done_cnt;
        int          first;
        logic [31:0] res_at;
        done_cnt = 0;
        first    = -1;
        res_at   = 32'h0;
        @(negedge clk);
        start  = 1'b1;
        n      = op;
        dataa  = d;
        clk_en = 1'b1;
        for (int c = 1; c <= exp_cyc + 3; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (first < 0) begin
                    first  = c;
                    res_at = result;
                end
            end
            if (trace) begin
                check_eq($sformatf("%s busy c%0d", tag, c), {31'h0, busy},
                         {31'h0, (c <= exp_cyc)});
                check_eq($sformatf("%s done c%0d", tag, c), {31'h0, done},
                         {31'h0, (c == exp_cyc)});
            end
            start  = (c == inject);
            n      = 2'd0;
            dataa  = 32'hDEADBEEF;
            clk_en = !(stall_lo != 0 && c >= stall_lo && c <= stall_hi);
        end
        start  = 1'b0;
        clk_en = 1'b1;
        check_eq({tag, " done cycle"}, 32'(first), 32'(exp_cyc));
        check_eq({tag, " done count"}, 32'(done_cnt), 32'd1);
        check_eq({tag, " result"}, res_at, exp_res);
        check_eq({tag, " result held"}, result, exp_res);
        check_eq({tag, " idle after"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int dcnt;
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b1;
        clk_en   = 1'b1;
        start    = 1'b0;
        n        = 2'd0;
        dataa    = 32'h0;

        #2 reset_n = 1'b0;
        #1;
        check_eq("reset result", result, 32'h0);
        check_eq("reset done", {31'h0, done}, 32'h0);
        check_eq("reset busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(2'd0, 32'h11223344, 5, 32'h44332211, 0, 0, 0, "bswap32", 1'b1);
        run_op(2'd1, 32'hAABBCCDD, 5, 32'hBBAADDCC, 0, 0, 0, "bswap16", 1'b0);

        run_op(2'd2, 32'h01000000, 5, 32'h00000001, 0, 0, 0, "accum1", 1'b0);
        run_op(2'd2, 32'h02000000, 5, 32'h00000003, 0, 0, 0, "accum2", 1'b0);
        run_op(2'd3, 32'h0, 1, 32'h00000003, 0, 0, 0, "readclr1", 1'b0);
        run_op(2'd3, 32'h0, 1, 32'h00000000, 0, 0, 0, "readclr2", 1'b0);

        run_op(2'd2, 32'hFFFFFFFF, 5, 32'hFFFFFFFF, 0, 0, 0, "preload", 1'b0);
        run_op(2'd2, 32'h01000000, 5, 32'h00000000, 2, 0, 0, "wrap", 1'b0);

        run_op(2'd0, 32'h0A0B0C0D, 7, 32'h0D0C0B0A, 0, 2, 3, "stall", 1'b0);

        // Start a fresh accumulation of 5, then reset in the middle of a LANE.
        run_op(2'd3, 32'h0, 1, 32'h00000000, 0, 0, 0, "readclr3", 1'b0);
        run_op(2'd2, 32'h05000000, 5, 32'h00000005, 0, 0, 0, "accum5", 1'b0);
        @(negedge clk);
        start = 1'b1;
        n     = 2'd0;
        dataa = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("pre-reset busy", {31'h0, busy}, 32'h1);
        #1 reset_n = 1'b0;
        #1;
        check_eq("midreset result", result, 32'h0);
        check_eq("midreset done", {31'h0, done}, 32'h0);
        check_eq("midreset busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        check_eq("no done after reset", 32'(dcnt), 32'd0);
        run_op(2'd3, 32'h0, 1, 32'h00000000, 0, 0, 0, "readclr post-reset", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/swap_ci_controller.md
# swap_ci_controller

Multi-cycle, extended-opcode Nios II custom instruction that sequences a single shared 8-bit byte lane to perform byte-order operations on 32-bit operands. It also keeps a running accumulator of byte-reversed words. It sits on the processor's custom-instruction slave port, alongside the existing single-cycle byte-swap instruction. It gives software endian conversion, halfword swap and a checksum of byte-reversed data, all through one instruction slot.

## Interface
Parameters: none.

Ports:
- clk  in  1  custom-instruction clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  high = block advances; low = all registers hold (stall).
- start  in  1  one-cycle instruction issue pulse; sampled only when clk_en=1.
- n  in  2  extended opcode, captured with start: 0 BSWAP32, 1 BSWAP16, 2 ACCUM, 3 READCLR.
- dataa  in  32  operand, captured with start.
- result  out  32  registered result; valid while done=1, holds until the next done.
- done  out  1  registered; high exactly one enabled cycle per instruction.
- busy  out  1  high in any state other than IDLE (debug/verification visibility).

## Operation
- Registers:
  - op_q[1:0] and src_q[31:0], captured on start.
  - work_q[31:0], the lane destination.
  - lane_cnt[1:0].
  - acc_q[31:0].
  - result, done.
  - state ∈ {IDLE, LANE, DONE}.
- IDLE, with start=1 and clk_en=1:
  - Capture n and dataa.
  - If n=3, go to DONE. Otherwise clear lane_cnt and go to LANE.
- LANE: one byte per enabled cycle, via a single 8-bit lane.
  - BSWAP32 and ACCUM: byte k of src_q goes to work_q byte 3−k.
  - BSWAP16: byte k of src_q goes to work_q byte (k XOR 1).
  - lane_cnt increments. After k=3, go to DONE.
- Transition into DONE, loaded on the same edge:
  - op 0/1: result ← work_q.
  - op 2: acc_q ← acc_q + work_q (mod 2^32, carry discarded); result ← the new sum.
  - op 3: result ← acc_q (old value); acc_q ← 0.
  - done ← 1.
- DONE → IDLE after one enabled cycle; done ← 0 on that edge.
- start while busy=1 (LANE or DONE) is ignored: no capture, no effect.
- start in the same enabled cycle in which DONE exits is also ignored. The next instruction issues from IDLE only.
- acc_q changes only on ACCUM/READCLR completion and on reset.

## Timing
- Reset (asynchronous assert, any time, including mid-LANE): state=IDLE, lane_cnt=0, result=0, done=0, busy=0, acc_q=0, work_q=0. Any in-flight instruction is discarded and produces no done.
- Cycle numbering: start high in enabled cycle 0.
  - op 0–2: busy=1 in cycles 1–5; LANE occupies cycles 1–4; done=1 and result valid in cycle 5. Latency is 5 enabled cycles.
  - op 3: done=1 in cycle 1 (latency 1).
  - Earliest next issue: cycle 6 (op 0–2) or cycle 2 (op 3).
- clk_en=0: state, counters, acc_q, result and done all hold.
  - A done held across stalled cycles still counts as one completion.
  - Each stalled cycle adds one cycle to the latency.
- done never goes high in two consecutive enabled cycles.

## Test plan
- Reset, then start n=0, dataa=0x11223344 → done only in cycle 5, result=0x44332211; busy high in cycles 1–5; done low afterwards; result still 0x44332211 in cycle 8.
- start n=1, dataa=0xAABBCCDD → cycle 5: result=0xBBAADDCC.
- ACCUM sequence:
  - n=2 dataa=0x01000000 → result 0x00000001.
  - n=2 dataa=0x02000000 → result 0x00000003.
  - n=3 → done in cycle 1, result 0x00000003.
  - n=3 again → result 0x00000000.
- Wrap and ignored start:
  - Preload acc to 0xFFFFFFFF via n=2 dataa=0xFFFFFFFF.
  - Then n=2 dataa=0x01000000 → result 0x00000000 (carry dropped).
  - A start pulse in cycle 2 of that instruction → ignored, exactly one done.
- clk_en=0 during cycles 2–3 of an n=0, dataa=0x0A0B0C0D instruction → done in cycle 7, result 0x0D0C0B0A.
- reset_n low mid-LANE (cycle 3) after acc=0x5 → done stays 0; result=0 and acc=0 immediately; a following n=3 returns 0x00000000.
